// File: rtl/weight_fetch_arbiter.sv
// Round-robin read arbiter that lets several layer fetch engines share one
// weight/bias memory read port. A burst lock lets the current owner keep the
// port, and a one-hot tag pipeline tells each requester which returned data
// belongs to it.
//
// Ports:
//   clk        - clock, all state on the rising edge
//   rst        - synchronous active-high reset
//   req        - per-requester read request
//   req_addr   - packed request addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_lock   - per-requester burst lock, honoured only for the granted requester
//   gnt        - one-hot grant, combinational from req in the same cycle
//   mem_ren    - memory read enable (any grant)
//   mem_addr   - memory read address of the granted requester, 0 when idle
//   mem_rdata  - memory read data, valid RD_LATENCY cycles after mem_ren
//   rvalid     - one-hot return strobe naming the owner of rdata
//   rdata      - returned read data, shared by all requesters
module weight_fetch_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          mem_ren,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One extra bit so last_gnt + offset never overflows before the wrap.
    localparam int unsigned SUM_W = IDX_W + 1;

    logic [IDX_W-1:0]                 last_gnt;
    logic                             lock_q;
    logic [RD_LATENCY-1:0][NUM_REQ-1:0] tag_pipe;

    logic             found;
    logic [IDX_W-1:0] sel_idx;
    logic [SUM_W-1:0] cand;

    // Grant selection: lock continuation first, otherwise round-robin
    // starting one past the last granted requester.
    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        cand     = '0;
        gnt      = '0;
        mem_ren  = 1'b0;
        mem_addr = '0;
        if (!rst && (req != '0)) begin
            if (lock_q && req[last_gnt]) begin
                found   = 1'b1;
                sel_idx = last_gnt;
            end else begin
                for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                    cand = {1'b0, last_gnt} + SUM_W'(k);
                    if (cand >= SUM_W'(NUM_REQ)) begin
                        cand = cand - SUM_W'(NUM_REQ);
                    end
                    if (!found && req[cand[IDX_W-1:0]]) begin
                        found   = 1'b1;
                        sel_idx = cand[IDX_W-1:0];
                    end
                end
            end
        end
        if (found) begin
            gnt[sel_idx] = 1'b1;
            mem_ren      = 1'b1;
            mem_addr     = req_addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Arbitration state and return-tag pipeline; reset drops in-flight tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= IDX_W'(NUM_REQ - 1);
            lock_q   <= 1'b0;
            tag_pipe <= '0;
        end else begin
            if (found) begin
                last_gnt <= sel_idx;
            end
            lock_q      <= found && req_lock[sel_idx];
            tag_pipe[0] <= gnt;
            for (int unsigned s = 1; s < RD_LATENCY; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign rvalid = tag_pipe[RD_LATENCY-1];
    assign rdata  = mem_rdata;

endmodule
